// File: rtl/axi_fb_fetch.sv
// axi_fb_fetch: streams a frame buffer from AXI memory into a first-word-fall-through
// prefetch FIFO. It issues one BURST_LEN read burst at a time and wraps at the end of the frame.
// Optional build macro: AXI_FB_FETCH_RLAST_CHECK_EN. When it is defined, rd_err also flags
// an rlast/beat-count disagreement or an unexpected rid.
module axi_fb_fetch #(
  parameter int         FIFO_DEPTH = 32,
  parameter int         BURST_LEN  = 16,
  parameter logic [4:0] RD_ID      = 5'd1
) (
  input  logic        aclk,
  input  logic        reset,
  input  logic        enable,
  input  logic        frame_start,
  input  logic [31:0] fb_base,
  input  logic [19:0] fb_words,
  output logic [4:0]  axi_arid,
  output logic [31:0] axi_araddr,
  output logic [7:0]  axi_arlen,
  output logic [2:0]  axi_arsize,
  output logic [1:0]  axi_arburst,
  output logic        axi_arlock,
  output logic [3:0]  axi_arcache,
  output logic [2:0]  axi_arprot,
  output logic        axi_arvalid,
  input  logic        axi_arready,
  input  logic [4:0]  axi_rid,
  input  logic [31:0] axi_rdata,
  input  logic [1:0]  axi_rresp,
  input  logic        axi_rlast,
  input  logic        axi_rvalid,
  output logic        axi_rready,
  output logic [31:0] pix_data,
  output logic        pix_valid,
  input  logic        pix_ready,
  output logic        rd_err
);

  localparam int PTR_W = $clog2(FIFO_DEPTH);
  localparam int CNT_W = (BURST_LEN > 1) ? $clog2(BURST_LEN) : 1;
  localparam logic [CNT_W-1:0] LAST_BEAT = CNT_W'(BURST_LEN - 1);
  // A new burst may only start when a whole burst of free slots is reserved.
  localparam logic [PTR_W:0]   ISSUE_MAX = (PTR_W+1)'(FIFO_DEPTH - BURST_LEN);

  typedef enum logic [1:0] {IDLE, ADDR, DATA, DRAIN} state_t;

  state_t             state_q, state_d;
  logic               arvalid_q, arvalid_d;
  logic               rready_q, rready_d;
  logic [31:0]        araddr_q, araddr_d;
  logic [19:0]        offset_q, offset_d;
  logic [CNT_W-1:0]   beat_q, beat_d;
  logic               drain_pend_q, drain_pend_d;
  logic               rd_err_q, rd_err_d;
  logic [PTR_W-1:0]   wr_ptr_q, wr_ptr_d;
  logic [PTR_W-1:0]   rd_ptr_q, rd_ptr_d;
  logic [PTR_W:0]     count_q, count_d;
  logic [31:0]        mem_q [FIFO_DEPTH];

  logic               beat_ok;
  logic               last_beat;
  logic               push;
  logic               pop;
  logic [19:0]        base_off;

  // Word offset of the next burst; wraps to the frame start after the final burst.
  function automatic logic [19:0] next_offset(input logic [19:0] off, input logic [19:0] words);
    logic [20:0] sum;
    sum = {1'b0, off} + 21'(BURST_LEN);
    if (sum >= {1'b0, words}) return '0;
    return sum[19:0];
  endfunction

  assign axi_arid    = RD_ID;
  assign axi_arlen   = 8'(BURST_LEN - 1);
  assign axi_arsize  = 3'b010;
  assign axi_arburst = 2'b01;
  assign axi_arlock  = 1'b0;
  assign axi_arcache = 4'b0000;
  assign axi_arprot  = 3'b000;
  assign axi_araddr  = araddr_q;
  assign axi_arvalid = arvalid_q;
  assign axi_rready  = rready_q;
  assign rd_err      = rd_err_q;
  assign pix_valid   = (count_q != '0);
  assign pix_data    = mem_q[rd_ptr_q];

`ifndef AXI_FB_FETCH_RLAST_CHECK_EN
  // Burst end comes from the beat counter alone, so rlast and rid carry no information here.
  logic unused_rsig;
  assign unused_rsig = ^{axi_rlast, axi_rid};
`endif

  // Next-state logic for the fetch FSM, burst bookkeeping, error flag and FIFO pointers.
  always_comb begin
    state_d      = state_q;
    arvalid_d    = arvalid_q;
    rready_d     = rready_q;
    araddr_d     = araddr_q;
    offset_d     = offset_q;
    beat_d       = beat_q;
    drain_pend_d = drain_pend_q;
    rd_err_d     = rd_err_q;
    push         = 1'b0;
    beat_ok      = axi_rvalid & rready_q;
    last_beat    = (beat_q == LAST_BEAT);
    base_off     = frame_start ? 20'd0 : offset_q;

    case (state_q)
      IDLE: begin
        if (enable && (count_q <= ISSUE_MAX)) begin
          state_d      = ADDR;
          arvalid_d    = 1'b1;
          araddr_d     = fb_base + {10'd0, base_off, 2'b00};
          drain_pend_d = 1'b0;
        end
      end
      ADDR: begin
        // The address already presented must complete its handshake even on a restart.
        if (frame_start) drain_pend_d = 1'b1;
        if (axi_arready) begin
          arvalid_d = 1'b0;
          rready_d  = 1'b1;
          beat_d    = '0;
          state_d   = (drain_pend_q || frame_start) ? DRAIN : DATA;
        end
      end
      DATA: begin
        if (beat_ok) begin
          push   = ~frame_start;
          beat_d = beat_q + 1'b1;
          if (last_beat) begin
            state_d  = IDLE;
            rready_d = 1'b0;
            beat_d   = '0;
            offset_d = next_offset(offset_q, fb_words);
          end else if (frame_start) begin
            state_d = DRAIN;
          end
        end else if (frame_start) begin
          state_d = DRAIN;
        end
      end
      DRAIN: begin
        if (beat_ok) begin
          beat_d = beat_q + 1'b1;
          if (last_beat) begin
            state_d  = IDLE;
            rready_d = 1'b0;
            beat_d   = '0;
          end
        end
      end
      default: state_d = IDLE;
    endcase

    if (frame_start) offset_d = '0;

    if (beat_ok && (axi_rresp != 2'b00)) rd_err_d = 1'b1;
`ifdef AXI_FB_FETCH_RLAST_CHECK_EN
    if (beat_ok && ((axi_rlast != last_beat) || (axi_rid != RD_ID))) rd_err_d = 1'b1;
`endif

    // A restart flushes the FIFO, and a flush takes priority over a consumer pop.
    pop = pix_valid & pix_ready & ~frame_start;
    if (frame_start) begin
      wr_ptr_d = '0;
      rd_ptr_d = '0;
      count_d  = '0;
    end else begin
      wr_ptr_d = push ? wr_ptr_q + 1'b1 : wr_ptr_q;
      rd_ptr_d = pop  ? rd_ptr_q + 1'b1 : rd_ptr_q;
      case ({push, pop})
        2'b10:   count_d = count_q + 1'b1;
        2'b01:   count_d = count_q - 1'b1;
        default: count_d = count_q;
      endcase
    end
  end

  // Control state registers with synchronous reset.
  always_ff @(posedge aclk) begin
    if (reset) begin
      state_q      <= IDLE;
      arvalid_q    <= 1'b0;
      rready_q     <= 1'b0;
      araddr_q     <= '0;
      offset_q     <= '0;
      beat_q       <= '0;
      drain_pend_q <= 1'b0;
      rd_err_q     <= 1'b0;
      wr_ptr_q     <= '0;
      rd_ptr_q     <= '0;
      count_q      <= '0;
    end else begin
      state_q      <= state_d;
      arvalid_q    <= arvalid_d;
      rready_q     <= rready_d;
      araddr_q     <= araddr_d;
      offset_q     <= offset_d;
      beat_q       <= beat_d;
      drain_pend_q <= drain_pend_d;
      rd_err_q     <= rd_err_d;
      wr_ptr_q     <= wr_ptr_d;
      rd_ptr_q     <= rd_ptr_d;
      count_q      <= count_d;
    end
  end

  // FIFO storage; contents are only meaningful where the pointers say so, so no reset.
  always_ff @(posedge aclk) begin
    if (push) mem_q[wr_ptr_q] <= axi_rdata;
  end

endmodule

// File: tb/tb_axi_fb_fetch.sv
// Testbench for axi_fb_fetch: a zero-latency AXI read slave model plus directed vector table
// and hand-written corner-case sequences.
module tb_axi_fb_fetch;

  logic        aclk = 1'b0;
  logic        reset = 1'b1;
  logic        enable = 1'b0;
  logic        frame_start = 1'b0;
  logic [31:0] fb_base = 32'h0040_0000;
  logic [19:0] fb_words = 20'd32;
  logic [4:0]  axi_arid;
  logic [31:0] axi_araddr;
  logic [7:0]  axi_arlen;
  logic [2:0]  axi_arsize;
  logic [1:0]  axi_arburst;
  logic        axi_arlock;
  logic [3:0]  axi_arcache;
  logic [2:0]  axi_arprot;
  logic        axi_arvalid;
  logic        axi_arready = 1'b1;
  logic [4:0]  axi_rid = 5'd1;
  logic [31:0] axi_rdata = '0;
  logic [1:0]  axi_rresp = 2'b00;
  logic        axi_rlast = 1'b0;
  logic        axi_rvalid = 1'b0;
  logic        axi_rready;
  logic [31:0] pix_data;
  logic        pix_valid;
  logic        pix_ready = 1'b0;
  logic        rd_err;

  axi_fb_fetch dut (
    .aclk(aclk), .reset(reset), .enable(enable), .frame_start(frame_start),
    .fb_base(fb_base), .fb_words(fb_words),
    .axi_arid(axi_arid), .axi_araddr(axi_araddr), .axi_arlen(axi_arlen),
    .axi_arsize(axi_arsize), .axi_arburst(axi_arburst), .axi_arlock(axi_arlock),
    .axi_arcache(axi_arcache), .axi_arprot(axi_arprot), .axi_arvalid(axi_arvalid),
    .axi_arready(axi_arready), .axi_rid(axi_rid), .axi_rdata(axi_rdata),
    .axi_rresp(axi_rresp), .axi_rlast(axi_rlast), .axi_rvalid(axi_rvalid),
    .axi_rready(axi_rready), .pix_data(pix_data), .pix_valid(pix_valid),
    .pix_ready(pix_ready), .rd_err(rd_err)
  );

  always #5 aclk = ~aclk;

  int          n_chk = 0;
  int          n_err = 0;
  // slave model state
  bit          s_active = 1'b0;
  int          s_beat = 0;
  logic [31:0] s_addr = '0;
  int          err_beat = -1;
  int          rlast_bad = -1;
  bit          ar_block = 1'b0;
  logic [31:0] ar_log [16];
  int          ar_cnt = 0;
  // consumer model state
  bit          chk_pop = 1'b0;
  int          pop_idx = 0;
  logic [31:0] cfg_base = 32'h0040_0000;
  int          cfg_words = 32;

  typedef struct {
    logic [31:0] base;
    int          words;
    logic        prdy;
    int          ncyc;
    int          nar;
    logic [31:0] ar0, ar1, ar2, ar3;
    bit          exact;
    int          min_pops;
  } vec_t;

  vec_t vecs [4];

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    n_chk++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s actual=%h required=%h", nm, act, exp);
    end
  endtask

  // Present slave outputs for the current cycle from the model state.
  task automatic drive();
    axi_arready = !ar_block;
    axi_rvalid  = s_active;
    axi_rdata   = s_addr + 32'(4 * s_beat);
    axi_rlast   = s_active && ((s_beat == 15) != (s_beat == rlast_bad));
    axi_rresp   = (s_active && s_beat == err_beat) ? 2'b10 : 2'b00;
    axi_rid     = 5'd1;
  endtask

  // One clock: note handshakes and pops seen before the edge, then update the model.
  task automatic cycle();
    bit          hs_ar, hs_r;
    logic [31:0] a;
    hs_ar = axi_arvalid && axi_arready;
    a     = axi_araddr;
    hs_r  = axi_rvalid && axi_rready;
    if (chk_pop && pix_valid && pix_ready && !frame_start && !reset) begin
      chk("pix_data", pix_data, cfg_base + 32'(4 * (pop_idx % cfg_words)));
      pop_idx++;
    end
    @(posedge aclk);
    #1;
    if (hs_ar) begin
      if (ar_cnt < 16) ar_log[ar_cnt] = a;
      ar_cnt++;
      s_active = 1'b1;
      s_addr   = a;
      s_beat   = 0;
    end else if (hs_r && s_active) begin
      s_beat++;
      if (s_beat == 16) begin
        s_active = 1'b0;
        s_beat   = 0;
      end
    end
    drive();
  endtask

  task automatic do_reset();
    reset = 1'b1;
    enable = 1'b0;
    frame_start = 1'b0;
    pix_ready = 1'b0;
    cycle();
    s_active = 1'b0;
    s_beat = 0;
    ar_cnt = 0;
    chk_pop = 1'b0;
    pop_idx = 0;
    err_beat = -1;
    rlast_bad = -1;
    ar_block = 1'b0;
    for (int i = 0; i < 16; i++) ar_log[i] = 32'hDEAD_BEEF;
    drive();
    cycle();
    reset = 1'b0;
  endtask

  task automatic wait_beat(input int n_ar, input int beat, input string nm);
    int k;
    k = 0;
    while (!(ar_cnt == n_ar && s_active && s_beat == beat) && k < 200) begin
      cycle();
      k++;
    end
    chk({nm, "_reached"}, 32'(k < 200), 32'd1);
  endtask

  task automatic set_frame(input logic [31:0] b, input int w);
    fb_base   = b;
    fb_words  = 20'(w);
    cfg_base  = b;
    cfg_words = w;
  endtask

  initial begin
    logic [31:0] ex [4];
    logic [31:0] a0;
    bit          leak;
    int          k;

    vecs[0] = '{32'h0040_0000, 32, 1'b1, 150, 3, 32'h0040_0000, 32'h0040_0040, 32'h0040_0000, 32'h0, 1'b0, 64};
    vecs[1] = '{32'h0040_0000, 32, 1'b0, 100, 2, 32'h0040_0000, 32'h0040_0040, 32'h0, 32'h0, 1'b1, 0};
    vecs[2] = '{32'h0000_1000, 48, 1'b1, 150, 4, 32'h0000_1000, 32'h0000_1040, 32'h0000_1080, 32'h0000_1000, 1'b0, 64};
    vecs[3] = '{32'hFFFF_FFC0, 32, 1'b1, 150, 3, 32'hFFFF_FFC0, 32'h0000_0000, 32'hFFFF_FFC0, 32'h0, 1'b0, 64};

    // reset state and constant AR fields
    do_reset();
    chk("rst_arvalid", axi_arvalid, 0);
    chk("rst_rready", axi_rready, 0);
    chk("rst_pix_valid", pix_valid, 0);
    chk("rst_rd_err", rd_err, 0);
    chk("rst_araddr", axi_araddr, 0);
    chk("ar_const", {axi_arid, axi_arlen, axi_arsize, axi_arburst, axi_arlock, axi_arcache, axi_arprot},
        {5'd1, 8'd15, 3'b010, 2'b01, 1'b0, 4'b0000, 3'b000});

    // table-driven streaming vectors
    for (int i = 0; i < 4; i++) begin
      do_reset();
      set_frame(vecs[i].base, vecs[i].words);
      pix_ready = vecs[i].prdy;
      chk_pop = 1'b1;
      pop_idx = 0;
      enable = 1'b1;
      repeat (vecs[i].ncyc) cycle();
      ex[0] = vecs[i].ar0; ex[1] = vecs[i].ar1; ex[2] = vecs[i].ar2; ex[3] = vecs[i].ar3;
      for (int j = 0; j < vecs[i].nar; j++) chk($sformatf("v%0d_ar%0d", i, j), ar_log[j], ex[j]);
      if (vecs[i].exact) begin
        chk($sformatf("v%0d_ar_count", i), ar_cnt, vecs[i].nar);
        chk($sformatf("v%0d_pix_valid", i), pix_valid, 1);
        chk($sformatf("v%0d_arvalid_idle", i), axi_arvalid, 0);
      end else begin
        chk($sformatf("v%0d_pops_enough", i), 32'(pop_idx >= vecs[i].min_pops), 1);
      end
    end

    // AR stall: address and valid held steady for 5 cycles, one handshake
    do_reset();
    set_frame(32'h0000_2000, 32);
    ar_block = 1'b1;
    drive();
    enable = 1'b1;
    k = 0;
    while (!axi_arvalid && k < 20) begin cycle(); k++; end
    chk("stall_arvalid_rise", 32'(k < 20), 1);
    enable = 1'b0;
    for (int i = 0; i < 5; i++) begin
      chk($sformatf("stall_arvalid_c%0d", i), axi_arvalid, 1);
      chk($sformatf("stall_araddr_c%0d", i), axi_araddr, 32'h0000_2000);
      cycle();
    end
    chk("stall_no_hs", ar_cnt, 0);
    ar_block = 1'b0;
    drive();
    repeat (40) cycle();
    chk("stall_one_hs", ar_cnt, 1);
    chk("stall_pix_valid", pix_valid, 1);
    chk("stall_rready_done", axi_rready, 0);

    // restart after beat 4 of the second burst
    do_reset();
    set_frame(32'h0040_0000, 32);
    enable = 1'b1;
    wait_beat(2, 5, "fs_beat4");
    chk("fs_ar1", ar_log[1], 32'h0040_0040);
    frame_start = 1'b1;
    cycle();
    frame_start = 1'b0;
    chk("fs_flushed", pix_valid, 0);
    leak = 1'b0;
    k = 0;
    while (ar_cnt < 3 && k < 100) begin
      if (pix_valid) leak = 1'b1;
      cycle();
      k++;
    end
    chk("fs_next_ar_seen", 32'(k < 100), 1);
    chk("fs_drain_no_push", leak, 0);
    chk("fs_next_ar_addr", ar_log[2], 32'h0040_0000);
    pop_idx = 0;
    chk_pop = 1'b1;
    pix_ready = 1'b1;
    repeat (30) cycle();
    chk("fs_restart_pops", 32'(pop_idx >= 16), 1);

    // error response on beat 3 sets a sticky flag
    do_reset();
    set_frame(32'h0040_0000, 32);
    err_beat = 3;
    drive();
    enable = 1'b1;
    wait_beat(1, 3, "err_beat3");
    chk("err_before", rd_err, 0);
    cycle();
    chk("err_after", rd_err, 1);
    err_beat = -1;
    repeat (40) cycle();
    chk("err_sticky", rd_err, 1);
    chk("err_data_pushed", pix_valid, 1);

`ifdef AXI_FB_FETCH_RLAST_CHECK_EN
    do_reset();
    set_frame(32'h0040_0000, 32);
    rlast_bad = 7;
    drive();
    enable = 1'b1;
    wait_beat(1, 7, "rlast_beat7");
    chk("rlast_before", rd_err, 0);
    cycle();
    chk("rlast_err", rd_err, 1);
`else
    do_reset();
    set_frame(32'h0040_0000, 32);
    rlast_bad = 7;
    drive();
    enable = 1'b1;
    repeat (40) cycle();
    chk("rlast_ignored", rd_err, 0);
    chk("rlast_ignored_burst", ar_cnt, 2);
`endif

    // reset during DATA abandons the burst
    do_reset();
    set_frame(32'h0040_0000, 32);
    err_beat = 0;
    drive();
    enable = 1'b1;
    wait_beat(1, 5, "rst_mid");
    chk("rst_mid_err_pre", rd_err, 1);
    chk("rst_mid_rready_pre", axi_rready, 1);
    reset = 1'b1;
    cycle();
    chk("rst_mid_arvalid", axi_arvalid, 0);
    chk("rst_mid_rready", axi_rready, 0);
    chk("rst_mid_pix_valid", pix_valid, 0);
    chk("rst_mid_rd_err", rd_err, 0);
    reset = 1'b0;

    $display("Result: errors=%0d of %0d checks", n_err, n_chk);
    $finish;
  end

endmodule
